// File: rtl/lcd_char_render_if.sv
// Byte stream from the character rasteriser to the ST7735 SPI writer.
// wr_data[8] is D/C (0 = command, 1 = data); a byte moves on wr_valid && wr_ready.
interface lcd_char_render_if;
  logic       wr_valid;
  logic [8:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_char_render.sv
// Rasterises one glyph per request into ST7735 window commands plus an RGB565
// pixel byte stream, then loops back to re-sample the upstream character.
module lcd_char_render #(
  parameter int X_OFFSET = 0,
  parameter int Y_OFFSET = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              show_char_flag_i,
  input  logic [6:0]        ascii_num_i,
  input  logic [8:0]        start_x_i,
  input  logic [8:0]        start_y_i,
  input  logic              en_size_i,
  input  logic [15:0]       front_color_i,
  input  logic [15:0]       background_color_i,
  output logic              show_char_done_o,
  output logic [10:0]       font_addr_o,
  output logic              font_sel_o,
  input  logic [7:0]        font_data_i,
  output logic              busy_o,
  lcd_char_render_if.master wr
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_CMD, S_FETCH, S_PIX, S_DONE, S_GAP
  } state_e;

  localparam logic [15:0] XOFF = 16'(X_OFFSET);
  localparam logic [15:0] YOFF = 16'(Y_OFFSET);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  row_q, row_d;
  logic        sub_q, sub_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [10:0] addr_q, addr_d;

  logic [6:0]  ascii_q;
  logic        sel_q;
  logic [15:0] xs_q, ys_q, fg_q, bg_q;

  logic        latch_en, fire;
  logic [3:0]  last_idx;
  logic [15:0] xe, ye, pix_col;
  logic [10:0] row_base;

  // Both fonts use the same terminal index: 2W-1 bytes per row equals H-1 rows.
  assign last_idx = sel_q ? 4'd15 : 4'd11;
  assign xe       = xs_q + (sel_q ? 16'd7 : 16'd5);
  assign ye       = ys_q + (sel_q ? 16'd15 : 16'd11);
  assign row_base = sel_q ? {ascii_q, 4'b0000}
                          : ({1'b0, ascii_q, 3'b000} + {2'b00, ascii_q, 2'b00});
  assign pix_col  = shreg_q[7] ? fg_q : bg_q;

  assign wr.wr_valid      = (state_q == S_CMD) || (state_q == S_PIX);
  assign fire             = wr.wr_valid && wr.wr_ready;
  assign show_char_done_o = (state_q == S_DONE);
  assign busy_o           = (state_q != S_IDLE) && (state_q != S_GAP);
  assign font_addr_o      = addr_q;
  assign font_sel_o       = sel_q;

  always_comb begin
    wr.wr_data = 9'h000;
    case (state_q)
      S_CMD: begin
        case (cnt_q)
          4'd0:    wr.wr_data = 9'h02A;
          4'd1:    wr.wr_data = {1'b1, xs_q[15:8]};
          4'd2:    wr.wr_data = {1'b1, xs_q[7:0]};
          4'd3:    wr.wr_data = {1'b1, xe[15:8]};
          4'd4:    wr.wr_data = {1'b1, xe[7:0]};
          4'd5:    wr.wr_data = 9'h02B;
          4'd6:    wr.wr_data = {1'b1, ys_q[15:8]};
          4'd7:    wr.wr_data = {1'b1, ys_q[7:0]};
          4'd8:    wr.wr_data = {1'b1, ye[15:8]};
          4'd9:    wr.wr_data = {1'b1, ye[7:0]};
          default: wr.wr_data = 9'h02C;
        endcase
      end
      // Even byte index carries the high colour byte, odd the low byte.
      S_PIX:   wr.wr_data = {1'b1, cnt_q[0] ? pix_col[7:0] : pix_col[15:8]};
      default: wr.wr_data = 9'h000;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    sub_d    = sub_q;
    shreg_d  = shreg_q;
    addr_d   = addr_q;
    latch_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (show_char_flag_i) begin
          state_d  = S_LATCH;
          latch_en = 1'b1;
        end
      end
      S_LATCH: begin
        state_d = S_CMD;
        cnt_d   = 4'd0;
      end
      S_CMD: begin
        if (fire) begin
          if (cnt_q == 4'd10) begin
            state_d = S_FETCH;
            cnt_d   = 4'd0;
            row_d   = 4'd0;
            sub_d   = 1'b0;
            addr_d  = row_base;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      // First cycle presents the address, second captures the ROM row.
      S_FETCH: begin
        if (!sub_q) begin
          sub_d = 1'b1;
        end else begin
          shreg_d = font_data_i;
          cnt_d   = 4'd0;
          state_d = S_PIX;
        end
      end
      S_PIX: begin
        if (fire) begin
          if (cnt_q[0]) shreg_d = {shreg_q[6:0], 1'b0};
          if (cnt_q == last_idx) begin
            cnt_d = 4'd0;
            if (row_q == last_idx) begin
              state_d = S_DONE;
            end else begin
              row_d   = row_q + 4'd1;
              sub_d   = 1'b0;
              addr_d  = addr_q + 11'd1;
              state_d = S_FETCH;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_GAP;
        sub_d   = 1'b0;
      end
      S_GAP: begin
        if (sub_q) begin
          state_d  = S_LATCH;
          latch_en = 1'b1;
        end else begin
          sub_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      sub_q   <= 1'b0;
      shreg_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      sub_q   <= sub_d;
      shreg_q <= shreg_d;
      addr_q  <= addr_d;
    end
  end

  // Snapshot of the upstream request; nothing upstream touches the glyph after this.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ascii_q <= '0;
      sel_q   <= 1'b0;
      xs_q    <= '0;
      ys_q    <= '0;
      fg_q    <= '0;
      bg_q    <= '0;
    end else if (latch_en) begin
      ascii_q <= ascii_num_i;
      sel_q   <= en_size_i;
      xs_q    <= {7'b0, start_x_i} + XOFF;
      ys_q    <= {7'b0, start_y_i} + YOFF;
      fg_q    <= front_color_i;
      bg_q    <= background_color_i;
    end
  end

endmodule

// File: tb/tb_lcd_char_render.sv
// Scoreboard bench for lcd_char_render: stimulus pushes expected bytes, monitors pop and compare.
module tb_lcd_char_render;

  typedef struct packed {
    logic [6:0]  a;
    logic [8:0]  x;
    logic [8:0]  y;
    logic        sz;
    logic [15:0] fg;
    logic [15:0] bg;
  } glyph_t;

  logic        sys_clk = 1'b0;
  logic        rst0_n, rst1_n, flag0, flag1, wr_ready;
  logic [6:0]  ascii_num;
  logic [8:0]  start_x, start_y;
  logic        en_size;
  logic [15:0] front_color, background_color;
  logic        done0, done1, sel0, sel1, busy0, busy1;
  logic [10:0] addr0, addr1;
  logic [7:0]  fdata0, fdata1;

  int checks = 0, failures = 0, cyc = 0;
  logic [8:0] q0[$], q1[$];
  glyph_t tbl [6];
  bit rdy_rand = 0, run0 = 0;
  int k0 = 0, F0 = 0, first_v0 = -1, a0_first = -1;
  int acc0 = 0, tot0 = 0, done_cnt0 = 0, tot1 = 0, done_cnt1 = 0;
  int done_cyc0[$];
  logic [8:0] cap0 [27];
  logic [8:0] cap1 [11];
  logic [10:0] a1_log[$];

  lcd_char_render_if if0 ();
  lcd_char_render_if if1 ();
  assign if0.wr_ready = wr_ready;
  assign if1.wr_ready = wr_ready;

  lcd_char_render #(.X_OFFSET(0), .Y_OFFSET(0)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst_n(rst0_n), .show_char_flag_i(flag0),
    .ascii_num_i(ascii_num), .start_x_i(start_x), .start_y_i(start_y),
    .en_size_i(en_size), .front_color_i(front_color), .background_color_i(background_color),
    .show_char_done_o(done0), .font_addr_o(addr0), .font_sel_o(sel0),
    .font_data_i(fdata0), .busy_o(busy0), .wr(if0));

  lcd_char_render #(.X_OFFSET(1), .Y_OFFSET(2)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst_n(rst1_n), .show_char_flag_i(flag1),
    .ascii_num_i(ascii_num), .start_x_i(start_x), .start_y_i(start_y),
    .en_size_i(en_size), .front_color_i(front_color), .background_color_i(background_color),
    .show_char_done_o(done1), .font_addr_o(addr1), .font_sel_o(sel1),
    .font_data_i(fdata1), .busy_o(busy1), .wr(if1));

  always #5 sys_clk = ~sys_clk;
  initial forever begin @(posedge sys_clk); cyc++; end

  function automatic logic [7:0] rom_byte(input logic [10:0] a);
    logic [7:0] t;
    if (a == 11'd688) return 8'hA5;
    t = a[7:0] * 8'd7;
    return t ^ 8'h5A;
  endfunction

  always_ff @(posedge sys_clk) begin
    fdata0 <= rom_byte(addr0);
    fdata1 <= rom_byte(addr1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input glyph_t g);
    ascii_num = g.a; start_x = g.x; start_y = g.y; en_size = g.sz;
    front_color = g.fg; background_color = g.bg;
  endtask

  task automatic push_exp(input glyph_t g, input int xo, input int yo, input bit which);
    logic [15:0] xs, xe, ys, ye, col;
    logic [10:0] base;
    logic [7:0]  d;
    logic [8:0]  b[$];
    int w, h;
    w = g.sz ? 8 : 6;
    h = g.sz ? 16 : 12;
    xs = 16'(g.x) + 16'(xo); xe = xs + 16'(w - 1);
    ys = 16'(g.y) + 16'(yo); ye = ys + 16'(h - 1);
    b = '{9'h02A, {1'b1, xs[15:8]}, {1'b1, xs[7:0]}, {1'b1, xe[15:8]}, {1'b1, xe[7:0]},
          9'h02B, {1'b1, ys[15:8]}, {1'b1, ys[7:0]}, {1'b1, ye[15:8]}, {1'b1, ye[7:0]}, 9'h02C};
    base = g.sz ? 11'(g.a) * 11'd16 : 11'(g.a) * 11'd12;
    for (int r = 0; r < h; r++) begin
      d = rom_byte(base + 11'(r));
      for (int c = 0; c < w; c++) begin
        col = d[7 - c] ? g.fg : g.bg;
        b.push_back({1'b1, col[15:8]});
        b.push_back({1'b1, col[7:0]});
      end
    end
    foreach (b[i]) if (which) q1.push_back(b[i]); else q0.push_back(b[i]);
  endtask

  task automatic wait_done0(input int n, input int budget, input string nm);
    int t = 0;
    while (done_cnt0 < n && t < budget) begin @(negedge sys_clk); t++; end
    chk(nm, 32'(done_cnt0 >= n), 32'd1);
  endtask

  task automatic pulse0(input bit rec);
    @(posedge sys_clk); #1 flag0 = 1'b1;
    if (rec) F0 = cyc;
    @(posedge sys_clk); #1 flag0 = 1'b0;
  endtask

  initial forever begin
    @(posedge sys_clk); #1;
    wr_ready = rdy_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  initial begin : mon0
    logic [8:0] e, held;
    bit pstall, pdone;
    pstall = 0; pdone = 0; held = '0;
    forever begin
      @(negedge sys_clk);
      if (rst0_n) begin
        if (if0.wr_valid && first_v0 < 0) first_v0 = cyc;
        if (a0_first < 0 && addr0 != 11'd0) a0_first = int'(addr0);
        if (pstall && if0.wr_valid) chk("stall_hold0", 32'(if0.wr_data), 32'(held));
        pstall = if0.wr_valid && !wr_ready;
        held = if0.wr_data;
        if (if0.wr_valid && wr_ready) begin
          if (tot0 < 27) cap0[tot0] = if0.wr_data;
          tot0++; acc0++;
          if (q0.size() == 0) begin
            checks++; failures++;
            $display("FAIL extra_byte0 got=%0h exp=none", if0.wr_data);
          end else begin
            e = q0.pop_front();
            chk("byte0", 32'(if0.wr_data), 32'(e));
          end
        end
        if (done0) begin
          chk("q0_empty_at_done", q0.size(), 0);
          chk("done0_single", 32'(pdone), 0);
          done_cyc0.push_back(cyc);
          done_cnt0++; acc0 = 0;
        end
        pdone = done0;
      end else begin
        pstall = 0; pdone = 0;
      end
    end
  end

  initial begin : mon1
    logic [8:0] e;
    logic [10:0] last;
    last = '0;
    forever begin
      @(negedge sys_clk);
      if (rst1_n) begin
        if (addr1 != last) begin a1_log.push_back(addr1); last = addr1; end
        if (if1.wr_valid && wr_ready) begin
          if (tot1 < 11) cap1[tot1] = if1.wr_data;
          tot1++;
          if (q1.size() == 0) begin
            checks++; failures++;
            $display("FAIL extra_byte1 got=%0h exp=none", if1.wr_data);
          end else begin
            e = q1.pop_front();
            chk("byte1", 32'(if1.wr_data), 32'(e));
          end
        end
        if (done1) begin
          chk("q1_empty_at_done", q1.size(), 0);
          done_cnt1++;
        end
      end
    end
  end

  // Upstream model: advance to the next character on every done pulse.
  initial begin : upstream0
    glyph_t g, prev;
    forever begin
      @(negedge sys_clk);
      if (run0 && done0) begin
        #1;
        prev = tbl[k0 % 6];
        k0++;
        g = tbl[k0 % 6];
        set_in(g);
        push_exp(g, 0, 0, 1'b0);
        if (g.sz != prev.sz) begin
          @(negedge sys_clk); @(negedge sys_clk);
          chk("sel_before_latch", 32'(sel0), 32'(prev.sz));
          @(negedge sys_clk);
          chk("sel_latched_3cyc", 32'(sel0), 32'(g.sz));
        end
      end
    end
  end

  initial begin : main
    glyph_t g1;
    logic [8:0] hand0 [27];
    logic [8:0] hand1 [11];
    int t, vc;
    hand0 = '{9'h02A, 9'h100, 9'h130, 9'h100, 9'h137, 9'h02B, 9'h100, 9'h100, 9'h100, 9'h10F, 9'h02C,
              9'h1FF, 9'h1FF, 9'h1FA, 9'h120, 9'h1FF, 9'h1FF, 9'h1FA, 9'h120,
              9'h1FA, 9'h120, 9'h1FF, 9'h1FF, 9'h1FA, 9'h120, 9'h1FF, 9'h1FF};
    hand1 = '{9'h02A, 9'h100, 9'h102, 9'h100, 9'h107, 9'h02B, 9'h100, 9'h122, 9'h100, 9'h12D, 9'h02C};
    tbl[0] = '{7'd43,  9'd48,  9'd0,   1'b1, 16'hFFFF, 16'hFA20};
    tbl[1] = '{7'd5,   9'd100, 9'd200, 1'b0, 16'h07E0, 16'h001F};
    tbl[2] = '{7'd94,  9'd300, 9'd150, 1'b1, 16'hF800, 16'h0000};
    tbl[3] = '{7'd33,  9'd511, 9'd511, 1'b0, 16'h1234, 16'hABCD};
    tbl[4] = '{7'd60,  9'd0,   9'd100, 1'b1, 16'h0000, 16'hFFFF};
    tbl[5] = '{7'd2,   9'd256, 9'd7,   1'b0, 16'h5555, 16'hAAAA};
    g1     = '{7'd17,  9'd1,   9'd32,  1'b0, 16'hF81F, 16'h07FF};
    rst0_n = 0; rst1_n = 0; flag0 = 0; flag1 = 0; wr_ready = 1;
    set_in(tbl[0]);
    repeat (3) @(posedge sys_clk);
    #1 rst0_n = 1; rst1_n = 1;
    @(negedge sys_clk);
    chk("reset_out0", {if0.wr_valid, if0.wr_data, done0, addr0, sel0, busy0}, 0);
    chk("reset_out1", {if1.wr_valid, if1.wr_data, done1, addr1, sel1, busy1}, 0);

    // 12x6 glyph with panel offsets
    set_in(g1);
    push_exp(g1, 1, 2, 1'b1);
    @(posedge sys_clk); #1 flag1 = 1;
    @(posedge sys_clk); #1 flag1 = 0;
    t = 0;
    while (done_cnt1 < 1 && t < 400) begin @(negedge sys_clk); t++; end
    chk("done1_seen", 32'(done_cnt1 >= 1), 1);
    @(posedge sys_clk); #1 rst1_n = 0;
    for (int i = 0; i < 11; i++) chk("cmd1_hand", 32'(cap1[i]), 32'(hand1[i]));
    chk("rom1_addr_count", a1_log.size(), 12);
    for (int i = 0; i < 12 && i < a1_log.size(); i++) chk("rom1_addr", 32'(a1_log[i]), 204 + i);
    chk("bytes1_total", tot1, 155);

    // continuous 16x8 / 12x6 run, no backpressure
    k0 = 0; set_in(tbl[0]); push_exp(tbl[0], 0, 0, 1'b0); run0 = 1;
    pulse0(1'b1);
    wait_done0(3, 1200, "done0_first3");
    chk("flag_to_valid", first_v0 - F0, 2);
    chk("rom0_first_addr", a0_first, 688);
    for (int i = 0; i < 27; i++) chk("glyph0_hand", 32'(cap0[i]), 32'(hand0[i]));
    if (done_cyc0.size() >= 3) begin
      chk("period_12x6", done_cyc0[1] - done_cyc0[0], 183);
      chk("period_16x8", done_cyc0[2] - done_cyc0[1], 303);
    end

    // backpressure at 30 % ready
    rdy_rand = 1;
    wait_done0(5, 4000, "done0_stalled");
    repeat (10) @(negedge sys_clk);
    chk("busy_mid_glyph", 32'(busy0), 1);
    pulse0(1'b0);
    wait_done0(6, 4000, "done0_after_flag");

    // reset in the middle of the pixel stream
    t = 0;
    while (acc0 < 100 && t < 2000) begin @(negedge sys_clk); t++; end
    chk("reached_100_bytes", 32'(acc0 >= 100), 1);
    @(posedge sys_clk); #1;
    run0 = 0; rst0_n = 0;
    #1 chk("reset_mid_pix", {if0.wr_valid, if0.wr_data, done0, addr0, sel0, busy0}, 0);
    q0.delete(); acc0 = 0;
    repeat (3) @(posedge sys_clk);
    #1 rst0_n = 1;
    vc = 0;
    repeat (30) begin @(negedge sys_clk); if (if0.wr_valid) vc++; end
    chk("quiet_after_reset", vc, 0);

    // restart after reset needs a fresh flag
    rdy_rand = 0;
    k0 = 3; set_in(tbl[3]); push_exp(tbl[3], 0, 0, 1'b0);
    pulse0(1'b1);
    wait_done0(7, 600, "done0_restart");
    @(posedge sys_clk); #1 rst0_n = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog cycles=%0d", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
